// File: rtl/tap_controller_if.sv
// tap_controller_if -- serial test-access signal bundle for the TAP controller.
//
// master modport: the test host (drives TMS, TDI and the boundary-scan chain
//                 return BSChainTDO; observes TDO and the decode strobes).
// slave modport : the TAP controller itself.
//
// Signal protocol:
//   TMS, TDI and BSChainTDO carry no valid/ready pair. TMS and TDI are sampled
//   on every rising TCK. BSChainTDO is sampled on falling TCK while Shift-DR
//   selects the boundary chain. TDO changes only on falling TCK and carries a
//   meaningful shift bit exactly while TDOEnable is high. The state and
//   instruction strobes are level signals decoded from registered state.
//
// Signals:
//   TMS            test mode select
//   TDI            serial test data in
//   BSChainTDO     serial output of the last boundary-scan cell
//   TDO            serial test data out
//   TDOEnable      high while TDO carries shift data
//   CaptureDR      high in Capture-DR
//   ShiftDR        high in Shift-DR
//   UpdateDR       high in Update-DR
//   TestLogicReset high in Test-Logic-Reset
//   Extest, SamplePreload, Idcode, Bypass  one-hot current instruction
interface tap_controller_if;
  logic TMS;
  logic TDI;
  logic BSChainTDO;
  logic TDO;
  logic TDOEnable;
  logic CaptureDR;
  logic ShiftDR;
  logic UpdateDR;
  logic TestLogicReset;
  logic Extest;
  logic SamplePreload;
  logic Idcode;
  logic Bypass;

  modport master (
    output TMS, TDI, BSChainTDO,
    input  TDO, TDOEnable, CaptureDR, ShiftDR, UpdateDR, TestLogicReset,
    input  Extest, SamplePreload, Idcode, Bypass
  );

  modport slave (
    input  TMS, TDI, BSChainTDO,
    output TDO, TDOEnable, CaptureDR, ShiftDR, UpdateDR, TestLogicReset,
    output Extest, SamplePreload, Idcode, Bypass
  );
endinterface

// File: rtl/tap_controller.sv
// tap_controller -- IEEE 1149.1 test access port controller.
//
// Implements the 16-state TAP FSM, a 4-bit instruction register, a 1-bit
// bypass register and a 32-bit IDCODE register. The boundary-scan chain is
// external; its serial return enters on BSChainTDO.
//
// Parameters:
//   IDCODE_VALUE  device ID loaded by Capture-DR under IDCODE (bit 0 must be 1)
//
// Ports:
//   TCK      test clock; every register in this block is clocked by it
//   TRST     asynchronous active-low reset
//   tap      slave side of tap_controller_if (TMS/TDI in, TDO and strobes out)
//   state_o  debug view of the FSM state, IEEE 1149.1 recommended encoding
module tap_controller #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1490_0A3F
) (
  input  logic             TCK,
  input  logic             TRST,
  tap_controller_if.slave  tap,
  output logic [3:0]       state_o
);

  // Encoding follows the IEEE 1149.1 recommended state assignment so the debug
  // port reads the same as standard tooling.
  typedef enum logic [3:0] {
    S_EX2DR = 4'h0,
    S_EX1DR = 4'h1,
    S_SHDR  = 4'h2,
    S_PAUDR = 4'h3,
    S_SELIR = 4'h4,
    S_UPDDR = 4'h5,
    S_CAPDR = 4'h6,
    S_SELDR = 4'h7,
    S_EX2IR = 4'h8,
    S_EX1IR = 4'h9,
    S_SHIR  = 4'hA,
    S_PAUIR = 4'hB,
    S_RTI   = 4'hC,
    S_UPDIR = 4'hD,
    S_CAPIR = 4'hE,
    S_TLR   = 4'hF
  } tap_state_e;

  localparam logic [3:0] INSTR_EXTEST  = 4'b0000;
  localparam logic [3:0] INSTR_SAMPLE  = 4'b0001;
  localparam logic [3:0] INSTR_IDCODE  = 4'b0010;
  localparam logic [3:0] IR_CAPTURE    = 4'b0101;

  tap_state_e  state_q, state_d;
  logic [3:0]  ir_shift_q, ir_shift_d;
  logic        bypass_q, bypass_d;
  logic [31:0] idcode_q, idcode_d;
  logic [3:0]  instr_q, instr_d;
  logic        tdo_q, tdo_d;
  logic        tdo_en_q, tdo_en_d;

  logic        dec_extest, dec_sample, dec_idcode, dec_bypass;
  logic        dr_tdo;

  // ---------------------------------------------------------------------------
  // TAP state machine (rising TCK)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TLR:   state_d = tap.TMS ? S_TLR   : S_RTI;
      S_RTI:   state_d = tap.TMS ? S_SELDR : S_RTI;
      S_SELDR: state_d = tap.TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: state_d = tap.TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  state_d = tap.TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: state_d = tap.TMS ? S_UPDDR : S_PAUDR;
      S_PAUDR: state_d = tap.TMS ? S_EX2DR : S_PAUDR;
      S_EX2DR: state_d = tap.TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: state_d = tap.TMS ? S_SELDR : S_RTI;
      S_SELIR: state_d = tap.TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: state_d = tap.TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  state_d = tap.TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: state_d = tap.TMS ? S_UPDIR : S_PAUIR;
      S_PAUIR: state_d = tap.TMS ? S_EX2IR : S_PAUIR;
      S_EX2IR: state_d = tap.TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: state_d = tap.TMS ? S_SELDR : S_RTI;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= S_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction decode from the committed (falling-edge) instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_extest = (instr_q == INSTR_EXTEST);
    dec_sample = (instr_q == INSTR_SAMPLE);
    dec_idcode = (instr_q == INSTR_IDCODE);
    // 1111 and every undefined code fall through to BYPASS.
    dec_bypass = !(dec_extest || dec_sample || dec_idcode);
  end

  // ---------------------------------------------------------------------------
  // Shift registers (rising TCK). Capture loads on the edge that leaves the
  // Capture state; Shift moves one bit per edge spent in the Shift state.
  // Pause/Exit states fall through to the hold defaults.
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_shift_d = ir_shift_q;
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;
    unique case (state_q)
      S_CAPIR: ir_shift_d = IR_CAPTURE;
      S_SHIR:  ir_shift_d = {tap.TDI, ir_shift_q[3:1]};
      S_CAPDR: begin
        bypass_d = 1'b0;
        if (dec_idcode) begin
          idcode_d = IDCODE_VALUE;
        end
      end
      S_SHDR: begin
        bypass_d = tap.TDI;
        if (dec_idcode) begin
          idcode_d = {tap.TDI, idcode_q[31:1]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_shift_q <= 4'b0000;
      bypass_q   <= 1'b0;
      idcode_q   <= 32'h0000_0000;
    end else begin
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
      idcode_q   <= idcode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Falling-edge logic: instruction commit and TDO retiming. Updating on the
  // falling edge gives the half-cycle between TDO launch and the host's
  // rising-edge sample, and keeps the instruction stable across rising edges.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (dec_idcode) begin
      dr_tdo = idcode_q[0];
    end else if (dec_extest || dec_sample) begin
      dr_tdo = tap.BSChainTDO;
    end else begin
      dr_tdo = bypass_q;
    end
  end

  always_comb begin
    instr_d  = instr_q;
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    unique case (state_q)
      S_TLR:   instr_d = INSTR_IDCODE;
      S_UPDIR: instr_d = ir_shift_q;
      S_SHIR: begin
        tdo_d    = ir_shift_q[0];
        tdo_en_d = 1'b1;
      end
      S_SHDR: begin
        tdo_d    = dr_tdo;
        tdo_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      instr_q  <= INSTR_IDCODE;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: state strobes decode the state register only, so they cannot
  // glitch on TMS activity.
  // ---------------------------------------------------------------------------
  assign tap.TestLogicReset = (state_q == S_TLR);
  assign tap.CaptureDR      = (state_q == S_CAPDR);
  assign tap.ShiftDR        = (state_q == S_SHDR);
  assign tap.UpdateDR       = (state_q == S_UPDDR);

  assign tap.Extest         = dec_extest;
  assign tap.SamplePreload  = dec_sample;
  assign tap.Idcode         = dec_idcode;
  assign tap.Bypass         = dec_bypass;

  assign tap.TDO            = tdo_q;
  assign tap.TDOEnable      = tdo_en_q;

  assign state_o            = state_q;

endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller -- self-checking bench for tap_controller.
module tb_tap_controller;

  localparam logic [3:0] S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR  = 4'h2, S_PAUDR = 4'h3;
  localparam logic [3:0] S_SELIR = 4'h4, S_UPDDR = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7;
  localparam logic [3:0] S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR  = 4'hA, S_PAUIR = 4'hB;
  localparam logic [3:0] S_RTI   = 4'hC, S_UPDIR = 4'hD, S_CAPIR = 4'hE, S_TLR   = 4'hF;
  localparam logic [31:0] IDCODE_EXP = 32'h1490_0A3F;

  typedef struct { logic tms; logic [3:0] st; } walk_t;
  typedef struct { logic [3:0] code; logic [3:0] dec; } dec_t;  // dec = {Extest,SamplePreload,Idcode,Bypass}

  logic       tck;
  logic       trst;
  logic [3:0] state;
  tap_controller_if tif();

  tap_controller dut (
    .TCK     (tck),
    .TRST    (trst),
    .tap     (tif.slave),
    .state_o (state)
  );

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];
  walk_t walk_q[$];
  dec_t  dec_tab[$];
  logic  mon_en = 1'b0;
  logic  upd_seen = 1'b0;

  // ---------------- clock / reset ----------------
  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Flags any Update-DR / Update-IR visit while armed.
  always @(negedge tck) begin
    if (mon_en && (tif.UpdateDR === 1'b1 || state === S_UPDIR)) upd_seen = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic tms, input logic tdi, input logic bs);
    tif.TMS = tms;
    tif.TDI = tdi;
    tif.BSChainTDO = bs;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard pop: compares the current TDO bit against the oldest expectation.
  task automatic pop_check(input string name);
    logic [0:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: TDO=%b observed but no expected bit queued", name, tif.TDO);
    end else begin
      e = exp_q.pop_front();
      if (tif.TDO !== e[0] || tif.TDOEnable !== 1'b1) begin
        errors++;
        $display("FAIL %s: TDO=%b TDOEnable=%b expected TDO=%b TDOEnable=1",
                 name, tif.TDO, tif.TDOEnable, e[0]);
      end
    end
  endtask

  // From Run-Test/Idle: load val into IR (LSB first), end in Run-Test/Idle.
  task automatic shift_ir(input logic [3:0] val);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    pop_check("ir_capture");
    for (int i = 0; i < 4; i++) begin
      step(i == 3, val[i], 1'b0);
      if (i < 3) pop_check("ir_capture");
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // From Run-Test/Idle: n-bit DR shift; observation k sees bs[k] on BSChainTDO.
  task automatic shift_dr(input int n, input logic [63:0] tdi, input logic [63:0] bs, input string name);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, bs[0]);
    pop_check(name);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, tdi[i], (i < n - 1) ? bs[i + 1] : 1'b0);
      if (i < n - 1) pop_check(name);
    end
    check({name, "_exit_en"}, 32'(tif.TDOEnable), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_w(input logic tms, input logic [3:0] st);
    walk_t w;
    w.tms = tms;
    w.st  = st;
    walk_q.push_back(w);
  endtask

  task automatic add_d(input logic [3:0] code, input logic [3:0] dec);
    dec_t d;
    d.code = code;
    d.dec  = dec;
    dec_tab.push_back(d);
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [63:0] tv;
    logic [63:0] bv;
    logic [31:0] idv;
    logic [8:0]  exp_vec;
    idv = IDCODE_EXP;

    // FSM walk covering all 32 arcs, plus five-TMS=1 escapes from Pause-DR and Shift-IR.
    add_w(0,S_RTI);   add_w(0,S_RTI);   add_w(1,S_SELDR); add_w(0,S_CAPDR); add_w(0,S_SHDR);
    add_w(0,S_SHDR);  add_w(1,S_EX1DR); add_w(0,S_PAUDR); add_w(0,S_PAUDR); add_w(1,S_EX2DR);
    add_w(0,S_SHDR);  add_w(1,S_EX1DR); add_w(1,S_UPDDR); add_w(1,S_SELDR); add_w(1,S_SELIR);
    add_w(0,S_CAPIR); add_w(1,S_EX1IR); add_w(1,S_UPDIR); add_w(0,S_RTI);   add_w(1,S_SELDR);
    add_w(0,S_CAPDR); add_w(1,S_EX1DR); add_w(0,S_PAUDR); add_w(1,S_EX2DR); add_w(1,S_UPDDR);
    add_w(0,S_RTI);   add_w(1,S_SELDR); add_w(1,S_SELIR); add_w(1,S_TLR);   add_w(1,S_TLR);
    add_w(0,S_RTI);   add_w(1,S_SELDR); add_w(1,S_SELIR); add_w(0,S_CAPIR); add_w(0,S_SHIR);
    add_w(0,S_SHIR);  add_w(1,S_EX1IR); add_w(0,S_PAUIR); add_w(0,S_PAUIR); add_w(1,S_EX2IR);
    add_w(0,S_SHIR);  add_w(1,S_EX1IR); add_w(0,S_PAUIR); add_w(1,S_EX2IR); add_w(1,S_UPDIR);
    add_w(1,S_SELDR); add_w(1,S_SELIR); add_w(1,S_TLR);
    add_w(0,S_RTI);   add_w(1,S_SELDR); add_w(0,S_CAPDR); add_w(1,S_EX1DR); add_w(0,S_PAUDR);
    add_w(1,S_EX2DR); add_w(1,S_UPDDR); add_w(1,S_SELDR); add_w(1,S_SELIR); add_w(1,S_TLR);
    add_w(0,S_RTI);   add_w(1,S_SELDR); add_w(1,S_SELDR == S_SELDR ? S_SELIR : S_SELIR);
    add_w(0,S_CAPIR); add_w(0,S_SHIR);
    add_w(1,S_EX1IR); add_w(1,S_UPDIR); add_w(1,S_SELDR); add_w(1,S_SELIR); add_w(1,S_TLR);

    add_d(4'b1111, 4'b0001);
    add_d(4'b0110, 4'b0001);
    add_d(4'b0001, 4'b0100);
    add_d(4'b1010, 4'b0001);
    add_d(4'b0010, 4'b0010);
    add_d(4'b0000, 4'b1000);

    tif.TMS = 1'b1;
    tif.TDI = 1'b0;
    tif.BSChainTDO = 1'b0;
    trst = 1'b1;
    #1 trst = 1'b0;
    #11;

    // Reset state while TRST is held.
    check("rst_state", 32'(state), 32'(S_TLR));
    check("rst_outs", 32'({tif.TestLogicReset, tif.Idcode, tif.Extest, tif.SamplePreload,
                           tif.Bypass, tif.TDO, tif.TDOEnable}), 32'b1100000);
    check("rst_strobes", 32'({tif.CaptureDR, tif.ShiftDR, tif.UpdateDR}), 32'd0);
    @(negedge tck);
    #1 trst = 1'b1;

    // Five TMS=1 clocks after reset stay in Test-Logic-Reset.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("tlr_hold", 32'({tif.TestLogicReset, tif.Idcode, tif.TDOEnable}), 32'b110);
    end

    // Table-driven FSM walk.
    for (int i = 0; i < walk_q.size(); i++) begin
      step(walk_q[i].tms, 1'($urandom_range(0, 1)), 1'b0);
      exp_vec = {walk_q[i].st, walk_q[i].st == S_TLR, walk_q[i].st == S_CAPDR,
                 walk_q[i].st == S_SHDR, walk_q[i].st == S_UPDDR,
                 (walk_q[i].st == S_SHDR) || (walk_q[i].st == S_SHIR)};
      check($sformatf("walk[%0d]", i),
            32'({state, tif.TestLogicReset, tif.CaptureDR, tif.ShiftDR, tif.UpdateDR, tif.TDOEnable}),
            32'(exp_vec));
    end
    check("tlr_forces_idcode", 32'(tif.Idcode), 32'd1);

    // 32-bit IDCODE readout from Test-Logic-Reset.
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) exp_q.push_back(idv[k]);
    for (int k = 0; k < 64; k++) tv[k] = 1'($urandom_range(0, 1));
    shift_dr(32, tv, 64'd0, "idcode");

    // Instruction decode table.
    for (int i = 0; i < dec_tab.size(); i++) begin
      shift_ir(dec_tab[i].code);
      check($sformatf("decode[%b]", dec_tab[i].code),
            32'({tif.Extest, tif.SamplePreload, tif.Idcode, tif.Bypass}), 32'(dec_tab[i].dec));
    end

    // EXTEST: TDO follows the boundary chain.
    for (int k = 0; k < 64; k++) bv[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 8; k++) exp_q.push_back(bv[k]);
    shift_dr(8, 64'd0, bv, "extest");

    // BYPASS: fixed pattern 1,0,1,1 -> 0,1,0,1,1, then a random pattern.
    shift_ir(4'b1111);
    check("bypass_sel", 32'(tif.Bypass), 32'd1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    shift_dr(5, 64'b01101, 64'd0, "bypass_fixed");
    for (int k = 0; k < 64; k++) tv[k] = 1'($urandom_range(0, 1));
    exp_q.push_back(1'b0);
    for (int k = 0; k < 9; k++) exp_q.push_back(tv[k]);
    shift_dr(10, tv, 64'd0, "bypass_rand");

    // TRST mid IR shift aborts without any update.
    shift_ir(4'b0000);
    check("pre_abort_extest", 32'(tif.Extest), 32'd1);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    pop_check("abort_shift");
    step(1'b0, 1'b1, 1'b0);
    pop_check("abort_shift");
    step(1'b0, 1'b1, 1'b0);
    pop_check("abort_shift");
    trst = 1'b0;
    #1;
    check("abort_async", 32'({state, tif.TestLogicReset, tif.Idcode, tif.Extest, tif.TDO, tif.TDOEnable}),
          32'({S_TLR, 5'b11000}));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("abort_held", 32'(state), 32'(S_TLR));
    trst = 1'b1;
    check("abort_release", 32'(state), 32'(S_TLR));
    step(1'b0, 1'b0, 1'b0);
    check("first_edge_after_trst", 32'(state), 32'(S_RTI));
    mon_en = 1'b0;
    check("abort_no_update", 32'(upd_seen), 32'd0);

    // IDCODE through Exit1 / Pause x3 / Exit2 with no lost or repeated bit.
    for (int k = 0; k < 32; k++) exp_q.push_back(idv[k]);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    pop_check("pause_id");
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      pop_check("pause_id");
    end
    step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("pause_ex1", 32'({state, tif.TDOEnable}), 32'({S_EX1DR, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      check("pause_hold", 32'({state, tif.TDOEnable}), 32'({S_PAUDR, 1'b0}));
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    pop_check("pause_id");
    for (int i = 0; i < 21; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      pop_check("pause_id");
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Final report.
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameter IDCODE_VALUE, default 32'h1490_0A3F, is the device ID captured in the IDCODE data register; bit 0 SHALL be 1.
REQ-002 TCK input 1: the single test clock; all state SHALL be clocked by TCK.
REQ-003 TRST input 1: asynchronous, active-low reset.
REQ-004 TMS input 1: test mode select, sampled on posedge TCK.
REQ-005 TDI input 1: serial test data in.
REQ-006 BSChainTDO input 1: serial output of the last boundary scan cell.
REQ-007 TDO output 1: serial test data out.
REQ-008 TDOEnable output 1: high while TDO carries valid shift data.
REQ-009 CaptureDR, ShiftDR, UpdateDR output 1 each: high while the FSM is in Capture-DR, Shift-DR or Update-DR.
REQ-010 TestLogicReset output 1: high while the FSM is in Test-Logic-Reset.
REQ-011 Extest, SamplePreload, Idcode, Bypass output 1 each: one-hot decode of the current instruction.

Function
REQ-012 The FSM SHALL implement the 16 IEEE 1149.1 states, changing state on posedge TCK according to TMS.
REQ-013 Transitions with TMS=0 / TMS=1 SHALL be as follows.
- TLR: RTI / TLR
- RTI: RTI / SelDR
- SelDR: CapDR / SelIR
- CapDR: ShDR / Ex1DR
- ShDR: ShDR / Ex1DR
- Ex1DR: PauDR / UpdDR
- PauDR: PauDR / Ex2DR
- Ex2DR: ShDR / UpdDR
- UpdDR: RTI / SelDR
- SelIR: CapIR / TLR
- The IR branch (CapIR through UpdIR) SHALL mirror the DR branch.
REQ-014 Five consecutive TCK rising edges with TMS=1 SHALL reach TLR from any state.
REQ-015 The state decode outputs (REQ-009, REQ-010) SHALL be combinational from the state register and glitch-free, i.e. decoded from registered state only.
REQ-016 The IR shift register SHALL be 4 bits wide.
- Capture-IR: loads 4'b0101.
- Shift-IR: shifts right, TDI into bit 3, bit 0 toward TDO.
REQ-017 The current instruction SHALL be loaded from the IR shift register on negedge TCK while in Update-IR.
REQ-018 The current instruction SHALL be forced to IDCODE (4'b0010) on negedge TCK while in TLR.
REQ-019 Instruction decode SHALL be:
- 0000 = Extest
- 0001 = SamplePreload
- 0010 = Idcode
- 1111 = Bypass
- any other code = Bypass
REQ-020 The bypass register (1 bit) SHALL capture 0 in Capture-DR and load TDI in Shift-DR.
REQ-021 The 32-bit IDCODE register SHALL capture IDCODE_VALUE in Capture-DR when Idcode=1, and shift right with TDI into bit 31 in Shift-DR.
REQ-022 TDO source selection SHALL be:
- Shift-IR: IR bit 0
- Shift-DR with Idcode: IDCODE bit 0
- Shift-DR with Extest or SamplePreload: BSChainTDO
- Shift-DR with Bypass: bypass bit
REQ-023 TDO and TDOEnable SHALL be registered on negedge TCK; TDOEnable SHALL be 1 exactly for the half-cycles following Shift-IR or Shift-DR states.
REQ-024 The first bit out of any shift SHALL appear on TDO at the falling edge after the first posedge spent in a Shift state, i.e. a half-cycle latency.
REQ-025 The Pause and Exit states SHALL hold all shift registers unchanged.

Reset
REQ-026 TRST=0 SHALL immediately and asynchronously force the following, regardless of TCK:
- state = TLR
- current instruction = IDCODE
- IR shift register = 0
- bypass = 0
- IDCODE shift register = 0
- TDO = 0
- TDOEnable = 0
REQ-027 TRST asserted mid-shift SHALL abort the shift with no Update strobe generated.
REQ-028 After TRST deasserts, the first posedge SHALL evaluate TMS from TLR.

Verification
REQ-029 Pulse TRST low, then hold TMS=1 for 5 TCK -> TestLogicReset=1 and Idcode=1 throughout; TDOEnable=0.
REQ-030 From TLR, TMS sequence 0,1,0,0 then 32 TCK with TMS=0 in Shift-DR -> TDO emits 32'h1490_0A3F LSB first, and TDOEnable=1 for those 32 bits.
REQ-031 Shift IR value 4'b1111 then Update-IR -> Bypass=1; a DR shift of TDI pattern 1,0,1,1 -> TDO returns 0,1,0,1,1, i.e. one-cycle delay with a leading 0.
REQ-032 Load IR 4'b0110 (undefined code) -> Bypass=1; load 4'b0000 -> Extest=1; in Shift-DR, TDO follows BSChainTDO.
REQ-033 Enter Shift-IR and shift 2 bits, then assert TRST -> state TLR, instruction IDCODE, no UpdateIR/UpdateDR pulse, TDO=0.
REQ-034 Traverse Shift-DR -> Exit1 -> Pause (3 TCK) -> Exit2 -> Shift-DR -> IDCODE shifting resumes at the next bit with no bit lost or duplicated.
